cyq_sm2tc_ser: RTL and testbench
================================

# cyq_sm2tc_ser

Bit-serial sign-magnitude ("original code") to two's-complement encoder. It is the encode-side counterpart of our complement-to-original decode and compare path. The block accepts one W-bit sign-magnitude word per request and emits the two's-complement result LSB-first on a serial line with a valid strobe. It also presents the full word on a parallel port when the conversion completes. Its outputs feed the compare datapath and the serial test links on the board.

## Interface
- W, default 4: word width including sign bit (MSB = sign); legal range 2..16.
- CLK  in  1  single system clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  conversion request, sampled each rising edge.
- D  in  W  sign-magnitude input word; D[W-1] is the sign, D[W-2:0] is the magnitude; sampled only when START is accepted.
- BUSY  out  1  high while a conversion is in progress.
- SV  out  1  serial valid; SO carries a result bit this cycle.
- SO  out  1  serial result bit, LSB first.
- DONE  out  1  one-cycle pulse when Q is updated.
- Q  out  W  last completed two's-complement word; holds between conversions.
- MZ  out  1  high with Q when the last input was negative zero (sign=1, magnitude=0); holds with Q.

## Operation
- Registers:
  - shift register SR (W-1 bits, magnitude);
  - sign latch SG;
  - flag SEEN1, set once the first magnitude 1 has been emitted;
  - result accumulator ACC (W bits);
  - bit counter CNT (ceil(log2 W) bits).
- State IDLE:
  - BUSY=0, SV=0.
  - START=1 loads SR=D[W-2:0], SG=D[W-1], SEEN1=0, CNT=0, ACC=0, then moves to SHIFT.
- State SHIFT, one bit per cycle, SV=1, BUSY=1:
  - Magnitude bits, CNT=0..W-2. With m = SR[0]:
    - SO = m when SG=0 or SEEN1=0;
    - SO = ~m when SG=1 and SEEN1=1;
    - SEEN1 is set when m=1;
    - SR shifts right;
    - ACC[CNT] = SO.
  - Sign bit, CNT=W-1: SO = SG AND (magnitude≠0), with magnitude≠0 tracked as SEEN1. This bit is written to ACC[W-1].
  - After the sign bit the block moves to DONE.
- State DONE, one cycle:
  - Q is loaded from the completed ACC.
  - MZ = SG AND ~SEEN1.
  - DONE=1, BUSY=0, SV=0.
  - START=1 in this cycle is accepted exactly as in IDLE and moves to SHIFT (back-to-back operation); otherwise the block moves to IDLE.
- Arithmetic:
  - Result = magnitude for SG=0; result = 2^W − magnitude for SG=1 and magnitude≠0.
  - Negative zero encodes to all-zeros.
  - No overflow is possible: sign-magnitude spans ±(2^(W−1)−1), which two's complement of width W covers.
- START while in SHIFT is ignored; it is not queued, and D changes during SHIFT have no effect.
- RST=1 at any edge, including mid-SHIFT:
  - returns to IDLE;
  - clears SR, SG, SEEN1, CNT, ACC, Q, MZ, SO, SV, DONE, BUSY;
  - abandons any partial word, and Q is not updated.
- RST has priority over START in the same cycle.

## Timing
- Reset values: BUSY=0, SV=0, SO=0, DONE=0, Q=0, MZ=0; state IDLE.
- START accepted at edge t0. SV=1 during cycles t1..tW, with bit i valid in cycle t(i+1). DONE=1 with the new Q during cycle tW+1.
- Latency START→Q: W+1 cycles. Throughput: one word per W+1 cycles with START held high.
- SO=0 whenever SV=0. All outputs are registered; there is no combinational input-to-output path.
- Q and MZ change only on the DONE cycle or on reset.

## Test plan
- W=4, D=0101 (+5): SO sequence 1,0,1,0; DONE at t5; Q=0101; MZ=0.
- D=1101 (−5): SO sequence 1,1,0,1; Q=1011. Then D=1111 (−7): Q=1001. Then D=1001 (−1): Q=1111.
- D=1000 (−0): SO sequence 0,0,0,0; Q=0000; MZ=1. A following D=0000: Q=0000, MZ=0.
- Exhaustive sweep of all 16 D values, with Q checked against the reference formula and SO reassembled to equal Q.
- START held high with D changing each cycle:
  - conversions start at t0, t5, t10;
  - D is sampled only at those edges;
  - START pulses at t2 are ignored;
  - SV gaps are exactly one cycle.
- RST asserted at t2 of a −5 conversion:
  - next cycle all outputs are 0 and state is IDLE;
  - Q stays 0, with no DONE;
  - a new START with D=0011 yields Q=0011 five cycles later.

Source files
------------

// File: rtl/cyq_sm2tc_ser.sv
// cyq_sm2tc_ser: bit-serial sign-magnitude to two's-complement encoder, LSB first
module cyq_sm2tc_ser #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] d,
    output logic         busy,
    output logic         sv,
    output logic         so,
    output logic         done,
    output logic [W-1:0] q,
    output logic         mz
);
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, SHIFT, DN} state_t;
    state_t state, state_nx;
    logic [W-2:0] sr;
    logic sg, seen1;
    logic [W-1:0] acc;
    logic [CW-1:0] cnt;
    logic last, bit_out, load;
    // Copy bits up to the first 1, invert after it; sign bit is set only for nonzero negatives
    always_comb begin
        last = cnt == CW'(W - 1);
        bit_out = last ? (sg & seen1) : (sr[0] ^ (sg & seen1));
        load = state != SHIFT && start;
        busy = state == SHIFT;
        sv = state == SHIFT;
        so = (state == SHIFT) & bit_out;
        done = state == DN;
    end
    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // Next state: DONE behaves like IDLE for accepting a new request
    always_comb begin
        state_nx = state;
        state_nx = (state == SHIFT) ? (last ? DN : SHIFT) : (start ? SHIFT : IDLE);
    end
    // Datapath: load on accept, shift and accumulate while converting, publish on the last bit
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
            sg <= 1'b0;
            seen1 <= 1'b0;
            cnt <= '0;
            acc <= '0;
            q <= '0;
            mz <= 1'b0;
        end else if (load) begin
            sr <= d[W-2:0];
            sg <= d[W-1];
            seen1 <= 1'b0;
            cnt <= '0;
            acc <= '0;
        end else if (state == SHIFT) begin
            sr <= sr >> 1;
            seen1 <= seen1 | sr[0];
            acc[cnt] <= bit_out;
            cnt <= cnt + 1'b1;
            if (last) begin
                q <= {bit_out, acc[W-2:0]};
                mz <= sg & ~seen1;
            end
        end
    end
endmodule

// File: tb/tb_cyq_sm2tc_ser.sv
// tb_cyq_sm2tc_ser: directed self-checking bench for the serial sign-magnitude encoder
module tb_cyq_sm2tc_ser;
    localparam int W = 4;
    logic clk = 0, rst = 1, start = 0;
    logic [W-1:0] d = '0;
    logic busy, sv, so, done, mz;
    logic [W-1:0] q;
    int n_cmp = 0, n_bad = 0;

    cyq_sm2tc_ser #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .d(d),
        .busy(busy), .sv(sv), .so(so), .done(done), .q(q), .mz(mz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] ref_tc(input logic [W-1:0] v);
        logic [W-1:0] m;
        m = {1'b0, v[W-2:0]};
        return v[W-1] ? W'((1 << W) - m) : m;
    endfunction

    // Request a conversion and follow it to the DONE cycle, checking every serial bit
    task automatic convert(input logic [W-1:0] dv, input logic [W-1:0] eq, input logic emz, input string tag);
        logic [W-1:0] got;
        start = 1;
        d = dv;
        tick();
        start = 0;
        d = ~dv;
        got = '0;
        for (int i = 0; i < W; i++) begin
            chk({tag, "_sv"}, sv, 1);
            chk({tag, "_so"}, so, eq[i]);
            got[i] = so;
            if (i == 1) begin
                start = 1;
                tick();
                start = 0;
            end else tick();
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, {busy, sv, so}, 0);
        chk({tag, "_q"}, q, eq);
        chk({tag, "_ser"}, got, eq);
        chk({tag, "_mz"}, mz, emz);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_out", {busy, sv, so, done, mz}, 0);
        chk("rst_q", q, 0);
        rst = 0;
        tick();
        chk("idle", {busy, sv, so, done}, 0);
        convert(4'b0101, 4'b0101, 0, "p5");
        convert(4'b1101, 4'b1011, 0, "n5");
        convert(4'b1111, 4'b1001, 0, "n7");
        convert(4'b1001, 4'b1111, 0, "n1");
        tick();
        chk("hold_q", {q, done}, {4'b1111, 1'b0});
        convert(4'b1000, 4'b0000, 1, "nz");
        convert(4'b0000, 4'b0000, 0, "pz");
        for (int v = 0; v < 16; v++) convert(4'(v), ref_tc(4'(v)), v == 8, "sweep");
        tick();
        // START held with D changing every cycle: only every fifth edge samples D
        start = 1;
        for (int c = 0; c < 15; c++) begin
            d = 4'(c * 7 + 3);
            tick();
            chk("bb_sv", sv, (c % 5) != 4);
            chk("bb_done", done, (c % 5) == 4);
            if (c % 5 == 4) chk("bb_q", q, ref_tc(4'((c - 4) * 7 + 3)));
        end
        start = 0;
        tick();
        tick();
        // Reset mid-conversion of -5 abandons the word
        rst = 1;
        tick();
        rst = 0;
        start = 1;
        d = 4'b1101;
        tick();
        start = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_out", {busy, sv, so, done, mz}, 0);
        chk("mid_rst_q", q, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_rst_idle", {done, sv, q}, 0);
        end
        convert(4'b0011, 4'b0011, 0, "after_rst");
        tick();
        chk("final_idle", {busy, sv, done}, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
